// File: rtl/axi_lite_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_sram_slave
// Purpose  : AXI-lite style word-addressed SRAM slave with programmable fixed
//            read and write latency. It emulates slow memory behind the CPU
//            bus arbiter.
// Ports    : clock/reset       - single clock, async active-high reset
//            ar_* / r_*        - read address / read data channels
//            aw_* / w_* / b_*  - write address / data / response channels
//            busy              - high while either FSM is not idle
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_sram_slave #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          RD_LAT    = 2,
  parameter int          WR_LAT    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ar_valid,
  output logic        ar_ready,
  input  logic [31:0] ar_addr,
  output logic        r_valid,
  input  logic        r_ready,
  output logic [31:0] r_data,
  output logic [1:0]  r_resp,
  input  logic        aw_valid,
  output logic        aw_ready,
  input  logic [31:0] aw_addr,
  input  logic        w_valid,
  output logic        w_ready,
  input  logic [31:0] w_data,
  input  logic [3:0]  w_strb,
  output logic        b_valid,
  input  logic        b_ready,
  output logic [1:0]  b_resp,
  output logic        busy
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);
  localparam logic [3:0] WR_LAT_C = 4'(WR_LAT);
  localparam logic [1:0] OKAY     = 2'b00;
  localparam logic [1:0] SLVERR   = 2'b10;

  // Latencies must fit the 4-bit wait counters.
  if (RD_LAT < 0 || RD_LAT > 15) begin : g_rd_lat_illegal
    $error("axi_lite_sram_slave: RD_LAT must be in 0..15");
  end
  if (WR_LAT < 0 || WR_LAT > 15) begin : g_wr_lat_illegal
    $error("axi_lite_sram_slave: WR_LAT must be in 0..15");
  end
  if (ADDR_W < 1 || ADDR_W > 29) begin : g_addr_w_illegal
    $error("axi_lite_sram_slave: ADDR_W must be in 1..29");
  end

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} rd_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} wr_state_t;

  logic [31:0] mem [DEPTH];

  // ---------------------------------------------------------------- read side
  rd_state_t         rd_state, rd_next;
  logic [3:0]        rd_cnt;
  logic [31:0]       rd_addr;
  logic [31:0]       rd_src;
  logic [31:0]       rd_off;
  logic              rd_hit;
  logic [ADDR_W-1:0] rd_idx;
  logic              rd_load;

  // With zero latency the response is registered straight from the live
  // address in the handshake cycle, so the decode looks through the latch.
  always_comb begin
    rd_src  = (rd_state == R_IDLE) ? ar_addr : rd_addr;
    rd_off  = rd_src - BASE_ADDR;
    rd_hit  = (rd_src >= BASE_ADDR) && ((rd_off >> (ADDR_W + 2)) == 32'd0);
    rd_idx  = rd_off[ADDR_W+1:2];
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_valid && ar_ready) rd_next = (RD_LAT_C != 4'd0) ? R_WAIT : R_RESP;
      R_WAIT:  if (rd_cnt == 4'd1) rd_next = R_RESP;
      R_RESP:  if (r_ready) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
    rd_load = (rd_next == R_RESP) && (rd_state != R_RESP);
  end

  // Ready/valid are registered from the next state so they are all low while
  // reset is held; ar_ready therefore returns one cycle after an R handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_state <= R_IDLE;
      rd_cnt   <= 4'd0;
      rd_addr  <= 32'd0;
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= 32'd0;
      r_resp   <= OKAY;
    end else begin
      rd_state <= rd_next;
      ar_ready <= (rd_next == R_IDLE);
      r_valid  <= (rd_next == R_RESP);
      if (rd_state == R_IDLE && ar_valid && ar_ready) begin
        rd_addr <= ar_addr;
        rd_cnt  <= RD_LAT_C;
      end else if (rd_state == R_WAIT) begin
        rd_cnt <= rd_cnt - 4'd1;
      end
      if (rd_load) begin
        r_data <= rd_hit ? mem[rd_idx] : 32'd0;
        r_resp <= rd_hit ? OKAY : SLVERR;
      end
    end
  end

  // --------------------------------------------------------------- write side
  wr_state_t         wr_state, wr_next;
  logic [3:0]        wr_cnt;
  logic [31:0]       wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic              aw_have, w_have;
  logic              aw_have_nx, w_have_nx;
  logic              aw_hs, w_hs;
  logic [31:0]       wa_src, wd_src;
  logic [3:0]        ws_src;
  logic [31:0]       wr_off;
  logic              wr_hit;
  logic [ADDR_W-1:0] wr_idx;
  logic              wr_commit;

  always_comb begin
    aw_hs      = aw_valid && aw_ready;
    w_hs       = w_valid && w_ready;
    aw_have_nx = aw_have | aw_hs;
    w_have_nx  = w_have | w_hs;
    // A channel captured in this very cycle is taken from the bus directly.
    wa_src     = aw_have ? wr_addr : aw_addr;
    wd_src     = w_have ? wr_data : w_data;
    ws_src     = w_have ? wr_strb : w_strb;
    wr_off     = wa_src - BASE_ADDR;
    wr_hit     = (wa_src >= BASE_ADDR) && ((wr_off >> (ADDR_W + 2)) == 32'd0);
    wr_idx     = wr_off[ADDR_W+1:2];
    wr_next    = wr_state;
    case (wr_state)
      W_IDLE:  if (aw_have_nx && w_have_nx) wr_next = (WR_LAT_C != 4'd0) ? W_WAIT : W_RESP;
      W_WAIT:  if (wr_cnt == 4'd1) wr_next = W_RESP;
      W_RESP:  if (b_ready) begin
                 wr_next    = W_IDLE;
                 aw_have_nx = 1'b0;
                 w_have_nx  = 1'b0;
               end
      default: wr_next = W_IDLE;
    endcase
    wr_commit = (wr_next == W_RESP) && (wr_state != W_RESP);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_state <= W_IDLE;
      wr_cnt   <= 4'd0;
      wr_addr  <= 32'd0;
      wr_data  <= 32'd0;
      wr_strb  <= 4'd0;
      aw_have  <= 1'b0;
      w_have   <= 1'b0;
      aw_ready <= 1'b0;
      w_ready  <= 1'b0;
      b_valid  <= 1'b0;
      b_resp   <= OKAY;
    end else begin
      wr_state <= wr_next;
      aw_have  <= aw_have_nx;
      w_have   <= w_have_nx;
      aw_ready <= (wr_next == W_IDLE) && !aw_have_nx;
      w_ready  <= (wr_next == W_IDLE) && !w_have_nx;
      b_valid  <= (wr_next == W_RESP);
      if (aw_hs) wr_addr <= aw_addr;
      if (w_hs) begin
        wr_data <= w_data;
        wr_strb <= w_strb;
      end
      if (wr_state == W_IDLE && wr_next == W_WAIT) wr_cnt <= WR_LAT_C;
      else if (wr_state == W_WAIT)                 wr_cnt <= wr_cnt - 4'd1;
      if (wr_commit) b_resp <= wr_hit ? OKAY : SLVERR;
    end
  end

  // SRAM array is deliberately not reset. A read registered on the same edge
  // as a commit sees the old word because both use non-blocking updates.
  always_ff @(posedge clock) begin
    if (wr_commit && wr_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (ws_src[i]) mem[wr_idx][8*i +: 8] <= wd_src[8*i +: 8];
      end
    end
  end

  assign busy = (rd_state != R_IDLE) | (wr_state != W_IDLE);

endmodule
`default_nettype wire
